// File: rtl/cpu_trace_capture.sv
// cpu_trace_capture: records a triggered window of executed instructions
// from the single-cycle CPU into a circular buffer. The buffer drains through
// a first-word fall-through valid/ready stream.
//
// Optional feature: define TRACE_TIMESTAMP_EN to store a 32-bit free-running
// cycle count with every entry and expose it on out_ts.
module cpu_trace_capture #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 32
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      pc,
    input  logic [WIDTH-1:0]      inst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [WIDTH-1:0]      trig_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_pc,
    output logic [WIDTH-1:0]      out_inst,
`ifdef TRACE_TIMESTAMP_EN
    output logic [31:0]           out_ts,
`endif
    output logic [DEPTH_LOG2:0]   count,
    output logic [1:0]            state_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // A one-entry buffer still needs a (constant-zero) pointer bit.
    localparam int PTR_W = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_CAPTURE = 2'b10,
        S_DONE    = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;

    logic             wr_en;
    logic             flush;
    logic             pop;

    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [WIDTH-1:0] inst_mem [DEPTH];

    // Circular increment; explicit wrap keeps the one-entry build correct.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // FSM next state, capture counter and write enable; arm beats abort beats the FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d   = state_q;
        cap_cnt_d = cap_cnt_q;
        wr_en     = 1'b0;
        flush     = 1'b0;

        if (arm) begin
            flush     = 1'b1;
            cap_cnt_d = '0;
            state_d   = S_ARMED;
        end else if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_ARMED: begin
                    if (pc == trig_pc) begin
                        wr_en     = 1'b1;
                        cap_cnt_d = CNT_W'(1);
                        state_d   = (cap_cnt_d == DEPTH_CNT) ? S_DONE : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    wr_en     = 1'b1;
                    cap_cnt_d = cap_cnt_q + CNT_W'(1);
                    if (cap_cnt_d == DEPTH_CNT) begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE hold; the buffer keeps draining.
                end
            endcase
        end
    end

    // Pointer and occupancy update; a flush wins over any pop requested alongside it.
    always_comb begin
        pop      = out_valid && out_ready && !flush;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (wr_en) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            unique case ({wr_en, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state_q   <= S_IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            cap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            cap_cnt_q <= cap_cnt_d;
        end
    end

    // Trace storage write port.
    always_ff @(posedge clk_in) begin
        // NOTE: the array is not reset; count gates visibility, so stale contents are never presented.
        if (reset && wr_en) begin
            pc_mem[wr_ptr_q]   <= pc;
            inst_mem[wr_ptr_q] <= inst;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] ts_mem [DEPTH];

    // Free-running cycle counter; wraps naturally at 2**32.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end

    // Timestamp storage: the counter value at the write edge travels with the entry.
    always_ff @(posedge clk_in) begin
        if (reset && wr_en) begin
            ts_mem[wr_ptr_q] <= ts_q;
        end
    end

    assign out_ts = ts_mem[rd_ptr_q];
`endif

    assign out_valid = (count_q != '0);
    assign out_pc    = pc_mem[rd_ptr_q];
    assign out_inst  = inst_mem[rd_ptr_q];
    assign count     = count_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Self-checking bench for cpu_trace_capture (DEPTH_LOG2=2). A queue-based
// model tracks what the buffer must hold; a negedge process compares every
// cycle, and directed scenarios pin the model with literal expectations.
module tb_cpu_trace_capture;

    localparam int DL2   = 2;
    localparam int W     = 32;
    localparam int DEPTH = 1 << DL2;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  cpu_pc, cpu_inst, trig_pc;
    logic          arm, abort, out_ready;
    logic          out_valid;
    logic [W-1:0]  out_pc, out_inst;
    logic [DL2:0]  count;
    logic [1:0]    state_o;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]   out_ts;
`endif

    cpu_trace_capture #(.DEPTH_LOG2(DL2), .WIDTH(W)) dut (
        .clk_in    (clk),
        .reset     (reset),
        .pc        (cpu_pc),
        .inst      (cpu_inst),
        .arm       (arm),
        .abort     (abort),
        .trig_pc   (trig_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
`ifdef TRACE_TIMESTAMP_EN
        .out_ts    (out_ts),
`endif
        .count     (count),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] ts;
    } entry_t;

    entry_t      m_q[$];
    int          m_state = 0;   // 0 idle, 1 armed, 2 capture, 3 done
    int          m_cap   = 0;
    logic [31:0] m_ts    = 0;
    int          pops    = 0;
    bit          m_pop;
    entry_t      m_e;

    always @(posedge clk) begin
        if (!reset) begin
            m_q.delete();
            m_state = 0;
            m_cap   = 0;
            m_ts    = 0;
        end else begin
            m_pop = (m_q.size() != 0) && out_ready && !arm;
            if (m_pop) begin
                void'(m_q.pop_front());
                pops++;
            end
            m_e.pc   = cpu_pc;
            m_e.inst = cpu_inst;
            m_e.ts   = m_ts;
            if (arm) begin
                m_q.delete();
                m_cap   = 0;
                m_state = 1;
            end else if (abort && m_state != 0) begin
                m_state = 0;
            end else if (m_state == 1 && cpu_pc == trig_pc) begin
                m_q.push_back(m_e);
                m_cap   = 1;
                m_state = (m_cap == DEPTH) ? 3 : 2;
            end else if (m_state == 2) begin
                m_q.push_back(m_e);
                m_cap++;
                if (m_cap == DEPTH) m_state = 3;
            end
            m_ts = m_ts + 32'd1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 32'(state_o), 32'(m_state));
            check("count", 32'(count), 32'(m_q.size()));
            check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
            if (out_valid && m_q.size() != 0) begin
                check("out_pc", out_pc, m_q[0].pc);
                check("out_inst", out_inst, m_q[0].inst);
`ifdef TRACE_TIMESTAMP_EN
                check("out_ts", out_ts, m_q[0].ts);
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
        cpu_pc   = cpu_pc + 32'd4;
        cpu_inst = $urandom;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget);
        int n = 0;
        while (state_o !== s && n < budget) begin
            tick();
            n++;
        end
        check("wait_state", 32'(state_o), 32'(s));
    endtask

    initial begin
        int p0;
        reset     = 1'b0;
        arm       = 1'b1;
        abort     = 1'b0;
        out_ready = 1'b0;
        cpu_pc    = 32'h003F_FFF0;
        cpu_inst  = $urandom;
        trig_pc   = 32'h0040_0008;

        // Reset held with arm asserted: nothing may move.
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        arm   = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_state", 32'(state_o), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);

        // Capture 4 entries with the consumer stalled, then drain in order.
        cpu_pc = 32'h003F_FFFC;
        arm    = 1'b1;
        tick();
        arm = 1'b0;
        repeat (8) tick();
        check("cap_state", 32'(state_o), 32'h3);
        check("cap_count", 32'(count), 32'h4);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_pc", out_pc, 32'h0040_0008 + 32'(4 * i));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check("drain_empty", 32'(count), 32'h0);

        // Same window with the consumer always ready.
        out_ready = 1'b1;
        cpu_pc    = 32'h003F_FFFC;
        p0        = pops;
        arm       = 1'b1;
        tick();
        arm = 1'b0;
        repeat (10) begin
            tick();
            check("count_le1", 32'(count <= 1), 32'h1);
        end
        check("pop_total", 32'(pops - p0), 32'h4);
        check("ready_state", 32'(state_o), 32'h3);
        out_ready = 1'b0;

        // Re-arm mid-capture after two writes.
        trig_pc = cpu_pc + 32'd12;
        arm     = 1'b1;
        tick();
        arm = 1'b0;
        wait_state(2'b10, 10);
        tick();
        check("two_writes", 32'(count), 32'h2);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("rearm_count", 32'(count), 32'h0);
        check("rearm_valid", 32'(out_valid), 32'h0);
        check("rearm_state", 32'(state_o), 32'h1);
        trig_pc = cpu_pc + 32'd8;
        wait_state(2'b11, 20);
        check("recap_count", 32'(count), 32'h4);
        out_ready = 1'b1;
        repeat (5) tick();
        out_ready = 1'b0;

        // Abort after three writes; contents stay, no further capture.
        trig_pc = cpu_pc + 32'd12;
        arm     = 1'b1;
        tick();
        arm = 1'b0;
        wait_state(2'b10, 10);
        tick();
        tick();
        check("three_writes", 32'(count), 32'h3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", 32'(state_o), 32'h0);
        check("abort_count", 32'(count), 32'h3);
        trig_pc = cpu_pc;
        repeat (4) tick();
        check("idle_no_write", 32'(count), 32'h3);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        check("abort_drained", 32'(count), 32'h0);

        // Randomised traffic against the model.
        trig_pc = 32'h0040_0100;
        repeat (3000) begin
            tick();
            reset     = ($urandom_range(299) != 0);
            arm       = ($urandom_range(24) == 0);
            abort     = ($urandom_range(39) == 0);
            out_ready = ($urandom_range(2) != 0);
            if ($urandom_range(99) == 0) trig_pc = 32'h0040_0000 + {$urandom_range(63), 2'b00};
            if ($urandom_range(5) == 0) cpu_pc = trig_pc;
            else cpu_pc = 32'h0040_0000 + {$urandom_range(63), 2'b00};
        end
        reset = 1'b1;
        arm   = 1'b0;
        abort = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
